// File: rtl/psum_relu_quant_fifo.sv
// ----------------------------------------------------------------------------
// psum_relu_quant_fifo
//
// Downstream stage of the MAC array. Each accepted signed partial sum goes
// through ReLU, a right-shift requantization and unsigned saturation, which
// yields a bw-bit activation for the next layer. Results are buffered in a
// small FIFO with valid/ready handshakes on both sides. Each entry carries a
// tag that marks the last element of an output row.
//
// Ports:
//   clk        in   1              rising-edge clock
//   reset_n    in   1              asynchronous active-low reset
//   in_valid   in   1              in_psum is valid
//   in_ready   out  1              block can accept in_psum this cycle (!full)
//   in_psum    in   psum_bw        signed partial sum from the MAC
//   out_valid  out  1              out_act/out_last are valid (!empty)
//   out_ready  in   1              consumer accepts the current head entry
//   out_act    out  bw             unsigned quantized activation (0 when empty)
//   out_last   out  1              head entry closes a row (0 when empty)
//   count      out  log2(depth)+1  current occupancy
//   full       out  1              count == depth
//   empty      out  1              count == 0
//   sat_flag   out  1              sticky: some accepted psum saturated
// ----------------------------------------------------------------------------
module psum_relu_quant_fifo #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int shift   = 2,
  parameter int depth   = 8,
  parameter int row_len = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [psum_bw-1:0]       in_psum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [bw-1:0]            out_act,
  output logic                     out_last,
  output logic [$clog2(depth):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     sat_flag
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam int rw = (row_len > 1) ? $clog2(row_len) : 1;

  // Largest activation, zero-extended to the psum width for comparison.
  localparam logic [psum_bw-1:0] act_max_ext = psum_bw'((1 << bw) - 1);

  // ReLU + logical right shift + unsigned saturation.
  // Returns {saturated, act}.
  function automatic logic [bw:0] quantize(input logic [psum_bw-1:0] psum);
    logic [psum_bw-1:0] v;
    logic [bw:0]        res;
    v = psum >> shift;
    if (psum[psum_bw-1]) begin
      res = {1'b0, {bw{1'b0}}};
    end else if (v > act_max_ext) begin
      res = {1'b1, {bw{1'b1}}};
    end else begin
      res = {1'b0, v[bw-1:0]};
    end
    return res;
  endfunction

  // Storage: each entry is {last, act}. Contents are deliberately not reset.
  logic [bw:0]    mem_r [depth];
  logic [aw-1:0]  wr_ptr_r;
  logic [aw-1:0]  rd_ptr_r;
  logic [cw-1:0]  count_r;
  logic [rw-1:0]  row_cnt_r;
  logic           sat_r;

  logic           full_s;
  logic           empty_s;
  logic           wr_fire_s;
  logic           rd_fire_s;
  logic           row_last_s;
  logic [bw:0]    quant_s;
  logic [bw:0]    head_s;
  logic [cw-1:0]  count_nxt_s;
  logic [rw-1:0]  row_cnt_nxt_s;

  // Occupancy flags come straight from the count register, so they change only after an edge.
  always_comb begin
    full_s  = (count_r == cw'(depth));
    empty_s = (count_r == {cw{1'b0}});
  end

  // Handshake decode and per-write transform.
  always_comb begin
    wr_fire_s  = in_valid && !full_s;
    rd_fire_s  = !empty_s && out_ready;
    row_last_s = (row_cnt_r == rw'(row_len - 1));
    quant_s    = quantize(in_psum);
    head_s     = mem_r[rd_ptr_r];
  end

  // Next occupancy: a simultaneous write and read leave count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_fire_s, rd_fire_s})
      2'b10:   count_nxt_s = count_r + cw'(1);
      2'b01:   count_nxt_s = count_r - cw'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Next row position: advance on each write, wrap after the last column.
  always_comb begin
    row_cnt_nxt_s = row_cnt_r;
    if (wr_fire_s) begin
      if (row_last_s) begin
        row_cnt_nxt_s = {rw{1'b0}};
      end else begin
        row_cnt_nxt_s = row_cnt_r + rw'(1);
      end
    end else begin
      row_cnt_nxt_s = row_cnt_r;
    end
  end

  // Pointer, occupancy, row-position and sticky saturation state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r  <= {aw{1'b0}};
      rd_ptr_r  <= {aw{1'b0}};
      count_r   <= {cw{1'b0}};
      row_cnt_r <= {rw{1'b0}};
      sat_r     <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      row_cnt_r <= row_cnt_nxt_s;
      // depth is a power of two, so the pointers wrap naturally.
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + aw'(1);
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + aw'(1);
      end
      if (wr_fire_s && quant_s[bw]) begin
        sat_r <= 1'b1;
      end
    end
  end

  // Entry storage write port; no reset because stale data is never exposed.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_ptr_r] <= {row_last_s, quant_s[bw-1:0]};
    end
  end

  // Output drive: the head entry is visible without a request and is masked to zero when empty.
  always_comb begin
    in_ready  = !full_s;
    out_valid = !empty_s;
    full      = full_s;
    empty     = empty_s;
    count     = count_r;
    sat_flag  = sat_r;
    if (empty_s) begin
      out_act  = {bw{1'b0}};
      out_last = 1'b0;
    end else begin
      out_act  = head_s[bw-1:0];
      out_last = head_s[bw];
    end
  end

endmodule

// File: tb/tb_psum_relu_quant_fifo.sv
// ----------------------------------------------------------------------------
// Testbench for psum_relu_quant_fifo: directed sequences from the test plan
// followed by randomized traffic. A reference queue model holds the expected
// FIFO contents. The monitor compares every observable output on each falling
// edge and then applies the handshakes that fire on the coming rising edge.
// ----------------------------------------------------------------------------
module tb_psum_relu_quant_fifo;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int SHIFT   = 2;
  localparam int DEPTH   = 8;
  localparam int ROW_LEN = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [PSUM_BW-1:0]    in_psum;
  logic                  out_valid;
  logic                  out_ready;
  logic [BW-1:0]         out_act;
  logic                  out_last;
  logic [$clog2(DEPTH):0] count;
  logic                  full;
  logic                  empty;
  logic                  sat_flag;

  always #5 clk = ~clk;

  psum_relu_quant_fifo #(
    .bw(BW), .psum_bw(PSUM_BW), .shift(SHIFT), .depth(DEPTH), .row_len(ROW_LEN)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_act(out_act), .out_last(out_last),
    .count(count), .full(full), .empty(empty), .sat_flag(sat_flag)
  );

  typedef struct {
    int act;
    int last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   row_idx    = 0;
  int   sat_exp    = 0;
  bit   in_reset   = 1'b1;

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference transform in plain integer arithmetic; pushes the expected entry.
  function automatic void model_write(input logic [PSUM_BW-1:0] p);
    exp_t e;
    int   v;
    if (p[PSUM_BW-1]) begin
      e.act = 0;
    end else begin
      v = int'(p) / (2 ** SHIFT);
      if (v > (2 ** BW) - 1) begin
        e.act   = (2 ** BW) - 1;
        sat_exp = 1;
      end else begin
        e.act = v;
      end
    end
    e.last  = (row_idx == ROW_LEN - 1) ? 1 : 0;
    row_idx = (row_idx + 1) % ROW_LEN;
    exp_q.push_back(e);
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    int n;
    bit fire_w;
    bit fire_r;
    if (!in_reset) begin
      n = exp_q.size();
      chk("count", int'(count), n);
      chk("empty", int'(empty), (n == 0) ? 1 : 0);
      chk("full", int'(full), (n == DEPTH) ? 1 : 0);
      chk("in_ready", int'(in_ready), (n < DEPTH) ? 1 : 0);
      chk("out_valid", int'(out_valid), (n > 0) ? 1 : 0);
      chk("sat_flag", int'(sat_flag), sat_exp);
      if (n > 0) begin
        chk("out_act", int'(out_act), exp_q[0].act);
        chk("out_last", int'(out_last), exp_q[0].last);
      end else begin
        chk("out_act_empty", int'(out_act), 0);
        chk("out_last_empty", int'(out_last), 0);
      end
      fire_r = out_ready && (n > 0);
      fire_w = in_valid && (n < DEPTH);
      if (fire_r) begin
        void'(exp_q.pop_front());
      end
      if (fire_w) begin
        model_write(in_psum);
      end
    end
  end

  task automatic step(input bit v, input logic [PSUM_BW-1:0] p, input bit r);
    in_valid  = v;
    in_psum   = p;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 16'h0000, 1'b1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_sat_flag"}, int'(sat_flag), 0);
    chk({tag, "_out_act"}, int'(out_act), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    reset_n  = 1'b0;
    in_reset = 1'b1;
    exp_q.delete();
    row_idx = 0;
    sat_exp = 0;
    #1;
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    #1;
    in_reset = 1'b0;
  endtask

  initial begin
    logic [PSUM_BW-1:0] p;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_psum   = '0;
    out_ready = 1'b0;

    // 1. Reset with no clock edge yet.
    #2;
    check_reset_outputs("rst");
    @(posedge clk);
    #2;
    reset_n  = 1'b1;
    in_reset = 1'b0;

    // 2. Transform with out_ready low, then drain.
    step(1'b1, 16'h0010, 1'b0);
    step(1'b1, 16'hFFF0, 1'b0);
    step(1'b1, 16'h0003, 1'b0);
    step(1'b1, 16'h003C, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk("t2_count4", int'(count), 4);
    drain(5);

    // 3. Saturation and stickiness.
    step(1'b1, 16'h0040, 1'b0);
    step(1'b1, 16'h0004, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk("t3_sat", int'(sat_flag), 1);
    drain(3);

    // 4. Fill to full; the ninth write must be ignored.
    for (int i = 1; i <= 8; i++) begin
      p = 16'(i * 4);
      step(1'b1, p, 1'b0);
    end
    step(1'b1, 16'h0030, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk("t4_full", int'(full), 1);
    drain(9);

    // 5. Concurrent read/write at count 3 across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      p = 16'(4 + 4 * i);
      step(1'b1, p, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      p = 16'(8 + 4 * i);
      step(1'b1, p, 1'b1);
    end
    step(1'b0, 16'h0000, 1'b0);
    chk("t5_count3", int'(count), 3);
    drain(4);

    // 6. Mid-stream reset at count 5; row counter restarts.
    for (int i = 0; i < 5; i++) begin
      p = 16'(4 * (i + 1));
      step(1'b1, p, 1'b0);
    end
    mid_reset();
    step(1'b1, 16'h000C, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    chk("t6_act", int'(out_act), 3);
    chk("t6_last", int'(out_last), 0);
    drain(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        p = 16'($urandom());
      end else begin
        p = 16'($urandom_range(0, 80));
      end
      step(1'($urandom_range(0, 1)), p, ($urandom_range(0, 2) != 0));
      if (i == 200) begin
        mid_reset();
      end
    end
    drain(DEPTH + 2);
    chk("final_empty", int'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
